// File: rtl/midi_pkg.sv
// Shared MIDI constants and transmitter state encoding, used by both the
// MIDI input and output paths.
package midi_pkg;

    localparam int MIDI_BAUD            = 31250;
    localparam int SYS_CLK_HZ           = 50_000_000;
    localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / MIDI_BAUD;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/midi_out_if.sv
// Byte handshake between a MIDI byte source and the MIDI output transmitter.
interface midi_out_if;

    logic [7:0] byteInput;
    logic       byteInputValid;
    logic       byteInputReady;

    modport master (
        output byteInput,
        output byteInputValid,
        input  byteInputReady
    );

    modport slave (
        input  byteInput,
        input  byteInputValid,
        output byteInputReady
    );

endinterface

// File: rtl/midi_fifo.sv
// Synchronous byte FIFO with occupancy count; push is ignored when full and
// pop is ignored when empty.
module midi_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [7:0]                   push_data,
    input  logic                         pop,
    output logic [7:0]                   pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != FULL);
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/midi_out.sv
// MIDI OUT transmitter: buffers handshaked bytes and serialises them as
// 8N1 UART frames at CLKS_PER_BIT clocks per bit, idle high.
module midi_out
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    midi_out_if.slave  bus,
    output logic       uartStream,
    output logic       txBusy
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   FIFO_FULL  = CNT_W'(FIFO_DEPTH);

    tx_state_t          state;
    tx_state_t          state_next;
    logic [TIMER_W-1:0] bit_timer;
    logic [TIMER_W-1:0] timer_next;
    logic [2:0]         bit_index;
    logic [2:0]         index_next;
    logic [7:0]         shift_reg;
    logic [7:0]         shift_next;
    logic               line;
    logic               line_next;

    logic [CNT_W-1:0]   fifo_count;
    logic [7:0]         fifo_data;
    logic               push;
    logic               pop;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // push even on the cycle it pops.
    assign bus.byteInputReady = (fifo_count < FIFO_FULL);
    assign push               = bus.byteInputValid && bus.byteInputReady;
    assign uartStream         = line;
    assign txBusy             = (state != IDLE);

    midi_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.byteInput),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            line      <= 1'b1;
        end else begin
            state     <= state_next;
            bit_timer <= timer_next;
            bit_index <= index_next;
            shift_reg <= shift_next;
            line      <= line_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = bit_timer;
        index_next = bit_index;
        shift_next = shift_reg;
        line_next  = line;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                line_next = 1'b1;
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shift_next = fifo_data;
                    line_next  = 1'b0;
                    timer_next = '0;
                    state_next = START;
                end
            end

            START: begin
                if (bit_timer == TIMER_LAST) begin
                    timer_next = '0;
                    index_next = '0;
                    line_next  = shift_reg[0];
                    state_next = DATA;
                end else begin
                    timer_next = bit_timer + 1'b1;
                end
            end

            // The shifter always holds the current bit in [0], so the next
            // bit to drive is [1].
            DATA: begin
                if (bit_timer == TIMER_LAST) begin
                    timer_next = '0;
                    if (bit_index == 3'd7) begin
                        line_next  = 1'b1;
                        state_next = STOP;
                    end else begin
                        index_next = bit_index + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        line_next  = shift_reg[1];
                    end
                end else begin
                    timer_next = bit_timer + 1'b1;
                end
            end

            STOP: begin
                if (bit_timer == TIMER_LAST) begin
                    timer_next = '0;
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        shift_next = fifo_data;
                        line_next  = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = bit_timer + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/midi_out.md
# midi_out

MIDI output transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO and serialises them as standard 31,250 baud MIDI UART frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It is the transmit counterpart of the MIDI input path. It drives the MIDI OUT / THRU connector on the FX2-BB expansion header from the synth's 50 MHz system clock.

## Interface
- CLKS_PER_BIT, 1600, clock cycles per bit: 50 MHz / 31,250. Minimum 4.
- FIFO_DEPTH, 4, byte FIFO entries. Power of two, ≥2.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- byteInput  in  8  byte to transmit.
- byteInputValid  in  1  byteInput is valid this cycle.
- byteInputReady  out  1  FIFO can accept a byte. Equals (count < FIFO_DEPTH).
- uartStream  out  1  serial MIDI line, registered. Idle high.
- txBusy  out  1  high while the FIFO is non-empty or a frame is in progress.

## Operation
- Handshake: a byte is accepted on any rising edge where byteInputValid && byteInputReady. When ready is low, the sender holds the byte and valid; nothing is dropped or overwritten.
- FIFO: first-in first-out, with a count of 0..FIFO_DEPTH.
  - Push and pop on the same edge leave count unchanged.
  - Pop only happens when count > 0. Push only happens when count < FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line = 1. If count > 0: pop into the 8-bit shift register, drive line = 0, clear the bit timer, go to START.
  - START: hold line 0 for CLKS_PER_BIT cycles. Then drive bit 0 and go to DATA with bitIndex = 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, then the next bit is driven, LSB first. After bit 7 has completed, drive line = 1 and go to STOP.
  - STOP: hold line 1 for CLKS_PER_BIT cycles. At the end:
    - if count > 0, pop and go straight to START with line = 0 (no idle gap);
    - otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It wraps to 0 at every bit boundary. bitIndex is 3 bits.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have no extra cycles between the stop bit and the next start bit.
- No running-status or message parsing: bytes are sent verbatim.

## Timing
- Reset values:
  - uartStream = 1, txBusy = 0, byteInputReady = 1 (count = 0), state = IDLE.
  - Bit timer and bitIndex = 0. FIFO pointers = 0.
- Reset mid-frame aborts the frame: the line returns high on the reset edge and the FIFO is flushed. Reset overrides a simultaneous push.
- Latency from an accept on edge N, with FSM in IDLE and FIFO empty:
  - pop and start bit (line falls) on edge N+1;
  - the line stays low through edge N+1+CLKS_PER_BIT.
- txBusy rises on the edge after the first accept. It falls on the edge where STOP completes with count = 0, i.e. on the same edge the FSM enters IDLE.
- byteInputReady is derived combinationally from the registered count. It is low for the cycles where count == FIFO_DEPTH.
- Full with pop: a push is still refused that cycle, because ready reflects the registered count. The slot is available the next cycle.

## Structure
- Shared package midi_pkg holds:
  - MIDI_BAUD = 31250 and SYS_CLK_HZ = 50_000_000;
  - the default CLKS_PER_BIT = SYS_CLK_HZ/MIDI_BAUD;
  - the tx state encoding (IDLE/START/DATA/STOP). The input module shares the same constants.
- Sub-module midi_fifo: synchronous FIFO (push/pop/count, data width 8, depth FIFO_DEPTH). midi_out contains the handshake, FSM, bit timer and shift register.

## Test plan
All scenarios run with CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.
- Single byte 0x90 after reset:
  - line low 16 cycles starting the edge after accept;
  - then bits 0,0,0,0,1,0,0,1 at 16 cycles each;
  - then high 16 cycles; txBusy falls at cycle 160 after the start bit.
- Back-to-back 0x90, 0x3C, 0x7F pushed on consecutive cycles: three frames, 480 cycles of continuous activity, each start bit immediately following the previous stop bit, decoded bytes match in order.
- Overflow: valid held high with 6 distinct bytes while transmitting. Required:
  - exactly 5 are accepted before ready drops (1 in shifter, 4 in FIFO);
  - ready re-asserts after the first frame ends;
  - all 6 are transmitted in order, none lost.
- Ready-low hold: byteInput changes only after accept. The monitor confirms each byte is transmitted exactly once.
- Reset at cycle 70 of a 0x55 frame: line high on the reset edge, txBusy = 0, ready = 1, queued bytes discarded, no further falling edge.
- Reset deasserted, then push 0xF8: a clean frame follows, with first-bit timing identical to the single-byte case.
